serial_word_rx: RTL

//  Serial frame receiver: the far end of the team's parallel-in/serial-out shift path.

---
 rtl/serial_word_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx: framed serial-to-parallel receiver.
// Start/data/parity/stop deserializer with a one-deep VALID/READY output buffer.
module serial_word_rx #(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             D,
   input  logic             D_EN,
   input  logic             CLR_ERR,
   input  logic             READY,
   output logic [WIDTH-1:0] ll_out,
   output logic             VALID,
   output logic             BUSY,
   output logic             PAR_ERR,
   output logic             FRM_ERR,
   output logic             OVR
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic             pmis_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             busy_q;
   logic             par_q;
   logic             frm_q;
   logic             ovr_q;

   // Frame FSM, output buffer and sticky flags; later writes win so a
   // flag set overrides a same-edge clear, and a load overrides a drain.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         pmis_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         par_q   <= 1'b0;
         frm_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (valid_q && READY) begin
            valid_q <= 1'b0;
         end
         if (CLR_ERR) begin
            par_q <= 1'b0;
            frm_q <= 1'b0;
            ovr_q <= 1'b0;
         end
         if (D_EN) begin
            unique case (state_q)
               S_IDLE: begin
                  if (D) begin
                     state_q <= S_DATA;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                     pmis_q  <= 1'b0;
                  end
               end
               S_DATA: begin
                  shift_q <= {shift_q[WIDTH-2:0], D};
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     state_q <= PARITY_EN ? S_PAR : S_STOP;
                  end
               end
               S_PAR: begin
                  pmis_q  <= D ^ (^shift_q);
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (D) begin
                     frm_q <= 1'b1;
                  end else begin
                     if (pmis_q) begin
                        par_q <= 1'b1;
                     end
                     if (!valid_q || READY) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ll_out  = data_q;
   assign VALID   = valid_q;
   assign BUSY    = busy_q;
   assign PAR_ERR = par_q;
   assign FRM_ERR = frm_q;
   assign OVR     = ovr_q;

endmodule
